missile_ctrl_multi: RTL and testbench

Parametrised controller for one player interceptor missile. It covers the launch, flight, hit and expiry phases against a configurable number of enemy tracks. It sits between the mouse/fire front end and the Bresenham line drawer (`bren_go`/`bren_done`), and reports one-hot hits to the enemy spawners. Compared with the single-shot three-enemy controller, it adds:
- `N_ENEMY` channels
- a priority-encoded hit index
- a configurable frame margin
- a post-shot cooldown with a queued fire request
- an optional flight timeout

---
 rtl/missile_pkg.sv | 29 ++
 rtl/missile_hit_detect.sv | 40 ++++
 rtl/missile_ctrl_multi.sv | 158 +++++++++++++++
 tb/tb_missile_ctrl_multi.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/missile_pkg.sv
// Shared types and helpers for the interceptor missile controller.
package missile_pkg;

  localparam int N_ENEMY_MAX = 16;

  // 3-bit state encoding; codes 7 is illegal and recovers through ST_RESET.
  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SHOOT    = 3'd2,
    ST_FLYING   = 3'd3,
    ST_HIT      = 3'd4,
    ST_GONE     = 3'd5,
    ST_COOLDOWN = 3'd6
  } state_t;

  // Unsigned |a-b| truncated to 'width' bits; callers pass zero-extended
  // coordinates so the difference never wraps.
  function automatic logic [31:0] abs_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int width);
    logic [31:0] d;
    logic [31:0] mask;
    d    = (a >= b) ? (a - b) : (b - a);
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return d & mask;
  endfunction

endpackage

// File: rtl/missile_hit_detect.sv
// Combinational hit comparators for all enemy channels plus a
// lowest-index-wins priority encoder.
module missile_hit_detect
  import missile_pkg::*;
#(
  parameter int OUT_WIDTH    = 8,
  parameter int N_ENEMY      = 3,
  parameter int XY_PRECISION = 12
) (
  input  logic [OUT_WIDTH-1:0]              xflying,
  input  logic [OUT_WIDTH-1:0]              yflying,
  input  logic [N_ENEMY-1:0][OUT_WIDTH-1:0] xenemy,
  input  logic [N_ENEMY-1:0][OUT_WIDTH-1:0] yenemy,
  input  logic [N_ENEMY-1:0]                spawn_enemy,
  output logic                              any_hit,
  output logic [((N_ENEMY > 1) ? $clog2(N_ENEMY) : 1)-1:0] hit_sel
);

  localparam int HIT_W = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;

  logic [31:0] dx;
  logic [31:0] dy;

  // Scan from the top channel down so the lowest matching index is kept last.
  always_comb begin
    any_hit = 1'b0;
    hit_sel = '0;
    dx      = '0;
    dy      = '0;
    for (int i = N_ENEMY - 1; i >= 0; i--) begin
      dx = abs_diff(32'(xflying), 32'(xenemy[i]), OUT_WIDTH + 1);
      dy = abs_diff(32'(yflying), 32'(yenemy[i]), OUT_WIDTH + 1);
      if (spawn_enemy[i] && (dx <= 32'(XY_PRECISION)) && (dy <= 32'(XY_PRECISION))) begin
        any_hit = 1'b1;
        hit_sel = HIT_W'(i);
      end
    end
  end

endmodule

// File: rtl/missile_ctrl_multi.sv
// Interceptor missile controller: launch, flight, hit/expiry and cooldown
// against N_ENEMY tracks. Optional flight timeout enabled by defining
// MISSILE_TIMEOUT_EN.
module missile_ctrl_multi
  import missile_pkg::*;
#(
  parameter int OUT_WIDTH       = 8,
  parameter int N_ENEMY         = 3,
  parameter int FRAME_MIN       = 0,
  parameter int FRAME_MAX       = 255,
  parameter int FRAME_MARGIN    = 2,
  parameter int XY_PRECISION    = 12,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fired,
  input  logic                              valid_drawing,
  input  logic                              bren_done,
  input  logic [OUT_WIDTH-1:0]              xcursor,
  input  logic [OUT_WIDTH-1:0]              ycursor,
  input  logic [OUT_WIDTH-1:0]              xflying,
  input  logic [OUT_WIDTH-1:0]              yflying,
  input  logic [N_ENEMY-1:0][OUT_WIDTH-1:0] xenemy,
  input  logic [N_ENEMY-1:0][OUT_WIDTH-1:0] yenemy,
  input  logic [N_ENEMY-1:0]                spawn_enemy,
  output logic [N_ENEMY-1:0]                hit,
  output logic [((N_ENEMY > 1) ? $clog2(N_ENEMY) : 1)-1:0] hit_idx,
  output logic                              bren_go,
  output logic [OUT_WIDTH-1:0]              xflying_end,
  output logic [OUT_WIDTH-1:0]              yflying_end,
  output logic                              ready,
  output logic                              fire_pending
);

  localparam int HIT_W    = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
  localparam int CD_W     = (COOLDOWN_CYCLES > 2) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam int CD_LOAD  = (COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0;
  localparam int LO_BOUND = FRAME_MIN + FRAME_MARGIN;
  localparam int HI_BOUND = FRAME_MAX - FRAME_MARGIN;

  state_t             state;
  state_t             state_nxt;
  logic               any_hit;
  logic [HIT_W-1:0]   hit_sel;
  logic [HIT_W-1:0]   hit_sel_q;
  logic [CD_W-1:0]    cd_cnt;
  logic               off_screen;
  logic               timeout;
  logic [31:0]        xf32;
  logic [31:0]        yf32;

  missile_hit_detect #(
    .OUT_WIDTH   (OUT_WIDTH),
    .N_ENEMY     (N_ENEMY),
    .XY_PRECISION(XY_PRECISION)
  ) u_hit_detect (
    .xflying    (xflying),
    .yflying    (yflying),
    .xenemy     (xenemy),
    .yenemy     (yenemy),
    .spawn_enemy(spawn_enemy),
    .any_hit    (any_hit),
    .hit_sel    (hit_sel)
  );

  assign xf32 = 32'(xflying);
  assign yf32 = 32'(yflying);
  assign off_screen = ($signed(xf32) < LO_BOUND) || ($signed(yf32) < LO_BOUND) ||
                      ($signed(xf32) > HI_BOUND) || ($signed(yf32) > HI_BOUND);

`ifdef MISSILE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt;

  // Flight timer: cleared as FLYING is entered, counts every FLYING cycle.
  always_ff @(posedge clk) begin
    if (rst)                                   to_cnt <= '0;
    else if (state == ST_SHOOT && valid_drawing) to_cnt <= '0;
    else if (state == ST_FLYING)               to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state == ST_FLYING) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Next-state logic; FLYING exits in priority hit > off-screen > done > timeout.
  always_comb begin
    state_nxt = ST_RESET;
    case (state)
      ST_RESET:    state_nxt = ST_IDLE;
      ST_IDLE:     state_nxt = (fired || fire_pending) ? ST_SHOOT : ST_IDLE;
      ST_SHOOT:    state_nxt = valid_drawing ? ST_FLYING : ST_SHOOT;
      ST_FLYING: begin
        if (any_hit)                                  state_nxt = ST_HIT;
        else if (off_screen || bren_done || timeout)  state_nxt = ST_GONE;
        else                                          state_nxt = ST_FLYING;
      end
      ST_HIT,
      ST_GONE:     state_nxt = (COOLDOWN_CYCLES == 0) ? ST_IDLE : ST_COOLDOWN;
      ST_COOLDOWN: state_nxt = (cd_cnt == '0) ? ST_IDLE : ST_COOLDOWN;
      default:     state_nxt = ST_RESET;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RESET;
    else     state <= state_nxt;
  end

  // Cooldown down-counter: loaded while leaving HIT/GONE, terminal count 0.
  always_ff @(posedge clk) begin
    if (rst)                                   cd_cnt <= '0;
    else if (state == ST_HIT || state == ST_GONE) cd_cnt <= CD_W'(CD_LOAD);
    else if (state == ST_COOLDOWN && cd_cnt != '0) cd_cnt <= cd_cnt - 1'b1;
  end

  // Latch the winning channel on the cycle the hit is detected.
  always_ff @(posedge clk) begin
    if (rst)                               hit_sel_q <= '0;
    else if (state == ST_FLYING && any_hit) hit_sel_q <= hit_sel;
  end

  // Fire queue: set by fired after flight ends, cleared as SHOOT is entered.
  always_ff @(posedge clk) begin
    if (rst)
      fire_pending <= 1'b0;
    else if (state == ST_IDLE && state_nxt == ST_SHOOT)
      fire_pending <= 1'b0;
    else if (fired && (state == ST_HIT || state == ST_GONE || state == ST_COOLDOWN))
      fire_pending <= 1'b1;
  end

  // Registered outputs decoded from the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit         <= '0;
      hit_idx     <= '0;
      bren_go     <= 1'b0;
      xflying_end <= '0;
      yflying_end <= '0;
      ready       <= 1'b0;
    end else begin
      hit     <= (state == ST_HIT) ? (N_ENEMY'(1) << hit_sel_q) : '0;
      bren_go <= (state == ST_SHOOT) || (state == ST_FLYING);
      ready   <= (state == ST_IDLE);
      if (state == ST_HIT) hit_idx <= hit_sel_q;
      if (state == ST_IDLE || state == ST_SHOOT) begin
        xflying_end <= xcursor;
        yflying_end <= ycursor;
      end
    end
  end

endmodule

// File: tb/tb_missile_ctrl_multi.sv
// Directed self-checking bench for missile_ctrl_multi (default parameters,
// TIMEOUT_CYCLES = 8 so the optional timeout is quick to observe).
module tb_missile_ctrl_multi;

  logic            clk = 1'b0;
  logic            rst;
  logic            fired;
  logic            valid_drawing;
  logic            bren_done;
  logic [7:0]      xcursor, ycursor, xflying, yflying;
  logic [2:0][7:0] xenemy, yenemy;
  logic [2:0]      spawn_enemy;
  logic [2:0]      hit;
  logic [1:0]      hit_idx;
  logic            bren_go;
  logic [7:0]      xflying_end, yflying_end;
  logic            ready;
  logic            fire_pending;

  int total = 0;
  int bad   = 0;
  int n;

  missile_ctrl_multi #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .fired        (fired),
    .valid_drawing(valid_drawing),
    .bren_done    (bren_done),
    .xcursor      (xcursor),
    .ycursor      (ycursor),
    .xflying      (xflying),
    .yflying      (yflying),
    .xenemy       (xenemy),
    .yenemy       (yenemy),
    .spawn_enemy  (spawn_enemy),
    .hit          (hit),
    .hit_idx      (hit_idx),
    .bren_go      (bren_go),
    .xflying_end  (xflying_end),
    .yflying_end  (yflying_end),
    .ready        (ready),
    .fire_pending (fire_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bounded wait for ready; returns the number of cycles taken (40 on expiry).
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (ready !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; fired = 1'b0; valid_drawing = 1'b0; bren_done = 1'b0;
    xcursor = 8'd100; ycursor = 8'd100; xflying = 8'd128; yflying = 8'd128;
    xenemy = '0; yenemy = '0; spawn_enemy = '0;
    for (int i = 0; i < 3; i++) begin
      xenemy[i] = 8'd200;
      yenemy[i] = 8'd200;
    end
    tick(); tick();
    check("rst_hit", 32'(hit), 0);
    check("rst_bren_go", 32'(bren_go), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_xend", 32'(xflying_end), 0);
    rst = 1'b0;
    tick(); tick();
    check("idle_ready", 32'(ready), 1);
    check("idle_xend", 32'(xflying_end), 100);

    // Test 1: single-channel hit on enemy 1.
    fired = 1'b1; tick();
    fired = 1'b0; tick();
    check("t1_bren_go_shoot", 32'(bren_go), 1);
    check("t1_ready_shoot", 32'(ready), 0);
    valid_drawing = 1'b1; tick();
    valid_drawing = 1'b0;
    xflying = 8'd105; yflying = 8'd95;
    xenemy[1] = 8'd100; yenemy[1] = 8'd100; spawn_enemy = 3'b010;
    xcursor = 8'd20;
    tick();
    check("t1_hit_early", 32'(hit), 0);
    tick();
    check("t1_hit", 32'(hit), 3'b010);
    check("t1_hit_idx", 32'(hit_idx), 1);
    check("t1_bren_go_off", 32'(bren_go), 0);
    check("t1_xend_frozen", 32'(xflying_end), 100);
    xflying = 8'd128; yflying = 8'd128;
    tick();
    check("t1_hit_pulse_end", 32'(hit), 0);
    check("t1_hit_idx_held", 32'(hit_idx), 1);

    // Test 4: fire request queued during cooldown.
    fired = 1'b1; tick();
    fired = 1'b0;
    check("t4_pending_set", 32'(fire_pending), 1);
    wait_ready(n);
    check("t4_cooldown_len", 32'(n), 15);
    check("t4_pending_clr", 32'(fire_pending), 0);
    tick();
    check("t4_auto_shoot", 32'(bren_go), 1);

    // Test 2: enemies 0 and 2 both in range, lowest index wins.
    valid_drawing = 1'b1; tick();
    valid_drawing = 1'b0;
    xflying = 8'd110; yflying = 8'd110;
    xenemy[0] = 8'd105; yenemy[0] = 8'd105;
    xenemy[2] = 8'd115; yenemy[2] = 8'd115;
    xenemy[1] = 8'd200; yenemy[1] = 8'd200;
    spawn_enemy = 3'b111;
    tick(); tick();
    check("t2_hit", 32'(hit), 3'b001);
    check("t2_hit_idx", 32'(hit_idx), 0);
    wait_ready(n);
    check("t2_cooldown_wait", 32'(n), 17);

    // Test 3a: off-screen at x=1 -> GONE, no hit.
    spawn_enemy = 3'b000;
    xflying = 8'd1; yflying = 8'd128;
    fired = 1'b1; tick();
    fired = 1'b0; valid_drawing = 1'b1; tick();
    valid_drawing = 1'b0; tick();
    check("t3a_flying", 32'(bren_go), 1);
    tick();
    check("t3a_gone_bren", 32'(bren_go), 0);
    check("t3a_no_hit", 32'(hit), 0);
    wait_ready(n);
    check("t3a_cooldown_wait", 32'(n), 17);

    // Test 3b: edge of frame stays in flight, fired ignored, bren_done ends it.
    fired = 1'b1; tick();
    fired = 1'b0; valid_drawing = 1'b1; tick();
    valid_drawing = 1'b0;
    xflying = 8'd2; yflying = 8'd253; fired = 1'b1;
    tick();
    fired = 1'b0;
    tick();
    check("t3b_edge_flying", 32'(bren_go), 1);
    check("t3b_fire_ignored", 32'(fire_pending), 0);
    xflying = 8'd50; yflying = 8'd50; bren_done = 1'b1;
    tick();
    bren_done = 1'b0;
    tick();
    check("t3b_done_bren", 32'(bren_go), 0);
    check("t3b_no_hit", 32'(hit), 0);
    wait_ready(n);
    check("t3b_cooldown_wait", 32'(n), 17);

    // Test 5: reset in flight with a match present.
    fired = 1'b1; tick();
    fired = 1'b0; valid_drawing = 1'b1; tick();
    valid_drawing = 1'b0;
    xflying = 8'd100; yflying = 8'd100;
    xenemy[0] = 8'd100; yenemy[0] = 8'd100; spawn_enemy = 3'b001;
    rst = 1'b1;
    tick();
    check("t5_hit", 32'(hit), 0);
    check("t5_bren_go", 32'(bren_go), 0);
    check("t5_hit_idx", 32'(hit_idx), 0);
    check("t5_xend", 32'(xflying_end), 0);
    check("t5_ready", 32'(ready), 0);
    rst = 1'b0; spawn_enemy = 3'b000;
    xflying = 8'd128; yflying = 8'd128;
    tick();
    check("t5_no_late_hit", 32'(hit), 0);
    wait_ready(n);
    check("t5_recover", 32'(n), 1);

    // Test 6: no end event; timeout build gives GONE after 8 FLYING cycles.
    fired = 1'b1; tick();
    fired = 1'b0; valid_drawing = 1'b1; tick();
    valid_drawing = 1'b0;
    repeat (8) tick();
    check("t6_still_flying", 32'(bren_go), 1);
    tick();
`ifdef MISSILE_TIMEOUT_EN
    check("t6_timeout", 32'(bren_go), 0);
`else
    check("t6_no_timeout", 32'(bren_go), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
